// File: rtl/div_unit.sv
// Multicycle restoring divider: one quotient bit per clock, then a sign-fix cycle.
// Optional DIV_UNSIGNED_EN adds an unsigned_op input for DIVU semantics.

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  // state | meaning
  // IDLE  | waiting for start; results held, done/div_zero pulses emitted here
  // RUN   | one restoring-division step per edge, WIDTH edges total
  // FIX   | apply quotient/remainder signs, write lo/hi, raise done
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             signed_op;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

`ifdef DIV_UNSIGNED_EN
  assign signed_op = ~unsigned_op;
`else
  assign signed_op = 1'b1;
`endif

  // One spare bit so divisors above 2^(WIDTH-1) (unsigned mode) still compare correctly.
  assign trial = {rem_q, dvd_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    done_d     = 1'b0;
    dz_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (b_in == '0) begin
            dz_d = 1'b1;
          end else begin
            dvd_d      = (signed_op && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
            dvs_d      = (signed_op && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;
            sign_quo_d = signed_op & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            sign_rem_d = signed_op & a_in[WIDTH-1];
            rem_d      = '0;
            cnt_d      = '0;
            state_d    = RUN;
          end
        end
      end

      RUN: begin
        // Dividend register doubles as the quotient: bits shift out the top, quotient bits in at the bottom.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end

      FIX: begin
        lo_d    = sign_quo_q ? (~dvd_q + 1'b1) : dvd_q;
        hi_d    = sign_rem_q ? (~rem_q + 1'b1) : rem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  assign lo_out   = lo_q;
  assign hi_out   = hi_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: signed cases, boundaries, divide-by-zero, busy start, mid-run reset.
// With DIV_UNSIGNED_EN defined it also exercises the unsigned_op input.

module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] lo_out;
  logic [31:0] hi_out;
  logic        busy;
  logic        done;
  logic        div_zero;
`ifdef DIV_UNSIGNED_EN
  logic        unsigned_op;
`endif

  int vectors;
  int miscompares;
  int lat;
  int done_count;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef DIV_UNSIGNED_EN
    .unsigned_op (unsigned_op),
`endif
    .a_in     (a_in),
    .b_in     (b_in),
    .lo_out   (lo_out),
    .hi_out   (hi_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after an edge; the next edge is E0.
  task automatic go(input logic [31:0] a, input logic [31:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges counted from the current point until done is seen (-1 on timeout).
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    go(a, b);
    chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk({tag, "_latency"}, lat, 32'd33);
    chk({tag, "_lo"}, lo_out, exp_lo);
    chk({tag, "_hi"}, hi_out, exp_hi);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    start       = 1'b0;
    a_in        = '0;
    b_in        = '0;
`ifdef DIV_UNSIGNED_EN
    unsigned_op = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_div("pos_7_2",   32'd7,        32'd2,        32'h0000_0003, 32'h0000_0001);
    run_div("neg_a",     32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("neg_b",     32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    run_div("neg_both",  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE);
    run_div("min_m1",    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    run_div("zero_dvd",  32'd0,        32'd5,        32'd0,        32'd0);
    run_div("small",     32'd5,        32'd7,        32'd0,        32'd5);

    // Divide by zero must leave the prior result intact.
    run_div("prior",     32'd7,        32'd2,        32'd3,        32'd1);
    go(32'd5, 32'd0);
    chk("dz_pulse", {29'd0, busy, done, div_zero}, 32'b001);
    @(posedge clk);
    #1;
    chk("dz_drop", {31'd0, div_zero}, 32'd0);
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_count++;
    end
    chk("dz_no_done", done_count, 32'd0);
    chk("dz_lo_held", lo_out, 32'd3);
    chk("dz_hi_held", hi_out, 32'd1);

    // A start while busy must not re-latch operands.
    go(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    go(32'd1, 32'd1);
    wait_done(lat);
    chk("busy_start_lat", lat, 32'd23);
    chk("busy_start_lo", lo_out, 32'd14);
    chk("busy_start_hi", hi_out, 32'd2);
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_count++;
    end
    chk("busy_start_single", done_count, 32'd0);

    // Asynchronous reset in the middle of a run.
    go(32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_lo", lo_out, 32'd0);
    chk("mid_rst_hi", hi_out, 32'd0);
    chk("mid_rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_count++;
    end
    chk("mid_rst_no_done", done_count, 32'd0);

`ifdef DIV_UNSIGNED_EN
    unsigned_op = 1'b1;
    run_div("udiv",      32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, 32'd1);
    run_div("udiv_big",  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,       32'hFFFF_FFFE);
    unsigned_op = 1'b0;
    run_div("sdiv_same", 32'hFFFF_FFFF, 32'd2,        32'd0,        32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
